// File: rtl/tick_debouncer.sv
// Tick-qualified debouncer: synchronises din, then accepts a level change only after it has
// persisted for STABLE_TICKS sample strobes. Emits registered rise/fall pulses on acceptance.
module tick_debouncer #(
    parameter int unsigned STABLE_TICKS = 4,
    parameter int unsigned CNT_WIDTH    = 3,
    parameter logic        RESET_LEVEL  = 1'b0
) (
    input  logic clk,
    input  logic nrst,
    input  logic tick,
    input  logic din,
    output logic dout,
    output logic rise,
    output logic fall,
    output logic busy
);

    localparam logic [0:0] ST_STABLE = 1'b0;
    localparam logic [0:0] ST_CHECK  = 1'b1;

    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(STABLE_TICKS - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);

    logic                 din_m;
    logic                 din_s;
    logic [0:0]           state_q, state_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                 dout_d;
    logic                 rise_d;
    logic                 fall_d;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            din_m <= RESET_LEVEL;
            din_s <= RESET_LEVEL;
        end else begin
            din_m <= din;
            din_s <= din_m;
        end
    end

    // A tick coinciding with entry into CHECK is not counted; reversion beats a final tick.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dout_d  = dout;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        case (state_q)
            ST_STABLE: begin
                if (din_s != dout) begin
                    state_d = ST_CHECK;
                    cnt_d   = '0;
                end
            end
            ST_CHECK: begin
                if (din_s == dout) begin
                    state_d = ST_STABLE;
                    cnt_d   = '0;
                end else if (tick) begin
                    if (cnt_q == CNT_LAST) begin
                        dout_d  = ~dout;
                        rise_d  = ~dout;
                        fall_d  = dout;
                        cnt_d   = '0;
                        state_d = ST_STABLE;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q <= ST_STABLE;
            cnt_q   <= '0;
            dout    <= RESET_LEVEL;
            rise    <= 1'b0;
            fall    <= 1'b0;
            busy    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dout    <= dout_d;
            rise    <= rise_d;
            fall    <= fall_d;
            busy    <= (state_d == ST_CHECK);
        end
    end

endmodule

// File: tb/tb_tick_debouncer.sv
// Bench for tick_debouncer: directed scenarios plus random din/tick traffic, checked through an
// event scoreboard fed by a reference model of the acceptance rules.
module tb_tick_debouncer;

    localparam int unsigned N  = 4;
    localparam bit          RL = 1'b0;

    logic clk = 1'b0;
    logic nrst;
    logic tick;
    logic din;
    logic dout;
    logic rise;
    logic fall;
    logic busy;

    always #5 clk = ~clk;

    tick_debouncer #(
        .STABLE_TICKS(N),
        .CNT_WIDTH   (3),
        .RESET_LEVEL (RL)
    ) dut (
        .clk (clk),
        .nrst(nrst),
        .tick(tick),
        .din (din),
        .dout(dout),
        .rise(rise),
        .fall(fall),
        .busy(busy)
    );

    typedef struct {
        bit is_rise;
        int cyc;
    } ev_t;

    ev_t exp_q[$];
    int  tests = 0;
    int  fails = 0;
    int  cyc   = 0;

    // Reference model state: synchronised view of din, accepted level, and the ticks
    // collected during the current uninterrupted mismatch streak.
    bit sync0 = RL;
    bit sync1 = RL;
    bit exp_dout = RL;
    bit streak = 1'b0;
    int streak_ticks[$];

    always @(posedge clk) begin
        #1;
        cyc = cyc + 1;
        if (!nrst) begin
            sync0    = RL;
            sync1    = RL;
            exp_dout = RL;
            streak   = 1'b0;
            streak_ticks.delete();
        end else begin
            if (sync1 == exp_dout) begin
                streak = 1'b0;
                streak_ticks.delete();
            end else if (!streak) begin
                // First mismatching cycle opens the streak; its tick does not count.
                streak = 1'b1;
                streak_ticks.delete();
            end else if (tick) begin
                streak_ticks.push_back(cyc);
                if (streak_ticks.size() == N) begin
                    exp_dout = ~exp_dout;
                    exp_q.push_back('{is_rise: exp_dout, cyc: cyc});
                    streak = 1'b0;
                    streak_ticks.delete();
                end
            end
            sync1 = sync0;
            sync0 = din;
        end
    end

    // Monitor: checks levels every cycle and matches pulses against the scoreboard.
    always @(posedge clk) begin
        #2;
        tests = tests + 1;
        if (dout !== exp_dout) begin
            fails = fails + 1;
            $display("FAIL dout cyc=%0d got=%b exp=%b", cyc, dout, exp_dout);
        end
        tests = tests + 1;
        if (busy !== streak) begin
            fails = fails + 1;
            $display("FAIL busy cyc=%0d got=%b exp=%b", cyc, busy, streak);
        end
        while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
            tests = tests + 1;
            fails = fails + 1;
            $display("FAIL missed_pulse cyc=%0d got=none exp=%s@%0d", cyc,
                     exp_q[0].is_rise ? "rise" : "fall", exp_q[0].cyc);
            void'(exp_q.pop_front());
        end
        if (rise || fall) begin
            tests = tests + 1;
            if (rise && fall) begin
                fails = fails + 1;
                $display("FAIL pulse_excl cyc=%0d got=rise&fall exp=one", cyc);
            end else if (exp_q.size() == 0) begin
                fails = fails + 1;
                $display("FAIL spurious_pulse cyc=%0d got=%s exp=none", cyc,
                         rise ? "rise" : "fall");
            end else begin
                ev_t e;
                e = exp_q.pop_front();
                if (e.is_rise != rise || e.cyc != cyc) begin
                    fails = fails + 1;
                    $display("FAIL pulse cyc=%0d got=%s exp=%s@%0d", cyc,
                             rise ? "rise" : "fall", e.is_rise ? "rise" : "fall", e.cyc);
                end
            end
        end
    end

    bit tick_en = 1'b1;
    int tcnt = 0;

    task automatic run(input int n);
        repeat (n) begin
            @(negedge clk);
            tick = tick_en && (tcnt == 7);
            tcnt = (tcnt + 1) % 8;
        end
    endtask

    initial begin
        nrst = 1'b0;
        din  = 1'b0;
        tick = 1'b0;
        repeat (3) @(negedge clk);
        nrst = 1'b1;
        run(20);
        // Clean press, then release.
        din = 1'b1;
        run(60);
        din = 1'b0;
        run(60);
        // Glitch lasting about two ticks.
        din = 1'b1;
        run(18);
        din = 1'b0;
        run(40);
        // No ticks: qualification never completes.
        tick_en = 1'b0;
        din = 1'b1;
        run(100);
        din = 1'b0;
        run(10);
        tick_en = 1'b1;
        // Reset in the middle of a qualification, released with din still high.
        din = 1'b1;
        run(22);
        nrst = 1'b0;
        run(4);
        nrst = 1'b1;
        run(60);
        din = 1'b0;
        run(60);
        // Random traffic: frequent din flips against random ticks.
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            if ($urandom_range(0, 15) == 0) din = ~din;
            tick = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 999) == 0) nrst = 1'b0;
            else if (!nrst && $urandom_range(0, 1) == 0) nrst = 1'b1;
        end
        nrst = 1'b1;
        run(80);
        repeat (2) @(posedge clk);
        #3;
        tests = tests + 1;
        if (exp_q.size() != 0) begin
            fails = fails + 1;
            $display("FAIL pending_pulses got=%0d exp=0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
